reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 19 +
 rtl/reset_sequencer_if.sv | 30 +++
 rtl/reset_sequencer_sync_vec.sv | 26 ++
 rtl/reset_sequencer.sv | 145 ++++++++++++++
 tb/tb_reset_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// Holds the sequencer state encoding and the loss counter width.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam int LOSS_W = 8;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Lock/reset bundle between the sequencer and its environment.
// master is the sequencer side, slave is the PLL/domain side.
interface reset_sequencer_if #(
    parameter int N_LOCK = 2,
    parameter int N_DOM  = 3
);
    import reset_seq_pkg::*;

    logic              ext_rst;
    logic [N_LOCK-1:0] lock_in;
    logic [N_LOCK-1:0] lock_mask;
    logic              pll_rst;
    logic [N_DOM-1:0]  dom_rst;
    logic              all_ready;
    logic [LOSS_W-1:0] loss_count;
    logic              timeout_err;

    modport master (
        input  ext_rst, lock_in, lock_mask,
        output pll_rst, dom_rst, all_ready,
        output loss_count, timeout_err
    );

    modport slave (
        output ext_rst, lock_in, lock_mask,
        input  pll_rst, dom_rst, all_ready,
        input  loss_count, timeout_err
    );

endinterface

// File: rtl/reset_sequencer_sync_vec.sv
// Multi-flop synchroniser for a vector of independent async flags.
// Each bit is synchronised on its own; no cross-bit coherency.
module sync_vec #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) r_q[i] <= '0;
        end else begin
            r_q[0] <= i_async;
            for (int i = 1; i < STAGES; i++) r_q[i] <= r_q[i-1];
        end
    end

    assign o_sync = r_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// PLL reset / lock-stability controller with staged domain release.
// Re-sequences on lock loss; retries the PLLs on lock timeout.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_LOCK         = 2,
    parameter int N_DOM          = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 8,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGE_GAP      = 16,
    parameter int LOCK_TIMEOUT   = 1048576
) (
    input logic               clk,
    input logic               rst_n,
    reset_sequencer_if.master bus
);

    localparam int MAX_CNT = max_of(max_of(PLL_RST_CYCLES, STABLE_CYCLES),
                                    max_of(STAGE_GAP, LOCK_TIMEOUT));
    localparam int CNT_W = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pll_rst;
    logic [N_DOM-1:0]  r_dom_rst;
    logic              r_all_ready;
    logic [LOSS_W-1:0] r_loss;
    logic              r_timeout;

    logic [N_LOCK-1:0] w_lock_s;
    logic              w_ext_s;
    logic              w_lock_ok;

    sync_vec #(.WIDTH(N_LOCK), .STAGES(SYNC_STAGES)) u_lock_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bus.lock_in),
        .o_sync  (w_lock_s)
    );

    sync_vec #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_ext_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bus.ext_rst),
        .o_sync  (w_ext_s)
    );

    // Masked-off PLLs count as locked
    assign w_lock_ok = &(w_lock_s | ~bus.lock_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PLL_RST;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_dom_rst   <= '1;
            r_all_ready <= 1'b0;
            r_loss      <= '0;
            r_timeout   <= 1'b0;
        end else if (w_ext_s) begin
            r_state     <= PLL_RST;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_dom_rst   <= '1;
            r_all_ready <= 1'b0;
        end else begin
            case (r_state)
                PLL_RST: begin
                    if (r_cnt == PLL_LAST) begin
                        r_state   <= WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (w_lock_ok) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TO_LAST) begin
                        r_state   <= PLL_RST;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!w_lock_ok) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == STB_LAST) begin
                        r_state   <= RELEASE;
                        r_cnt     <= '0;
                        r_dom_rst <= r_dom_rst << 1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RELEASE, RUN: begin
                    // Zeros shift in from bit 0, so domains release low-first
                    if (!w_lock_ok) begin
                        r_state     <= WAIT_LOCK;
                        r_cnt       <= '0;
                        r_dom_rst   <= '1;
                        r_all_ready <= 1'b0;
                        if (r_loss != '1) r_loss <= r_loss + 1'b1;
                    end else if (r_state == RELEASE) begin
                        if (!r_dom_rst[N_DOM-1]) begin
                            r_state     <= RUN;
                            r_all_ready <= 1'b1;
                        end else if (r_cnt == GAP_LAST) begin
                            r_cnt     <= '0;
                            r_dom_rst <= r_dom_rst << 1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= PLL_RST;
                    r_cnt       <= '0;
                    r_pll_rst   <= 1'b1;
                    r_dom_rst   <= '1;
                    r_all_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst     = r_pll_rst;
    assign bus.dom_rst     = r_dom_rst;
    assign bus.all_ready   = r_all_ready;
    assign bus.loss_count  = r_loss;
    assign bus.timeout_err = r_timeout;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random lock/ext traffic
// compared every cycle against a phase/elapsed-time model of the sequencer.
`timescale 1ns/1ps
module tb_reset_sequencer;

    localparam int NL   = 2;
    localparam int ND   = 3;
    localparam int SS   = 2;
    localparam int PLLC = 3;
    localparam int STB  = 8;
    localparam int GAP  = 4;
    localparam int TO   = 64;

    localparam int PH_PLL  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STB  = 2;
    localparam int PH_UP   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reset_sequencer_if #(.N_LOCK(NL), .N_DOM(ND)) bus();

    reset_sequencer #(
        .N_LOCK(NL), .N_DOM(ND), .SYNC_STAGES(SS),
        .PLL_RST_CYCLES(PLLC), .STABLE_CYCLES(STB),
        .STAGE_GAP(GAP), .LOCK_TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: phase plus cycles spent in it; inputs seen SS edges late
    int          m_ph   = PH_PLL;
    int          m_t    = 0;
    int          m_loss = 0;
    int          m_to   = 0;
    logic [NL-1:0] h_lk [SS];
    logic          h_ex [SS];

    function automatic int exp_dom();
        int d = (1 << ND) - 1;
        if (m_ph == PH_UP)
            for (int k = 0; k < ND; k++)
                if (m_t >= k * GAP) d &= ~(1 << k);
        return d;
    endfunction

    function automatic int exp_ready();
        return (m_ph == PH_UP && m_t >= (ND - 1) * GAP + 1) ? 1 : 0;
    endfunction

    initial begin
        for (int i = 0; i < SS; i++) begin h_lk[i] = '0; h_ex[i] = 1'b0; end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ph = PH_PLL; m_t = 0; m_loss = 0; m_to = 0;
                for (int i = 0; i < SS; i++) begin h_lk[i] = '0; h_ex[i] = 1'b0; end
            end else begin
                logic lk, ex;
                lk = &(h_lk[SS-1] | ~bus.lock_mask);
                ex = h_ex[SS-1];
                for (int i = SS - 1; i > 0; i--) begin
                    h_lk[i] = h_lk[i-1]; h_ex[i] = h_ex[i-1];
                end
                h_lk[0] = bus.lock_in;
                h_ex[0] = bus.ext_rst;
                if (ex) begin
                    m_ph = PH_PLL; m_t = 0;
                end else begin
                    case (m_ph)
                        PH_PLL:
                            if (m_t + 1 >= PLLC) begin m_ph = PH_WAIT; m_t = 0; end
                            else m_t++;
                        PH_WAIT:
                            if (lk) begin m_ph = PH_STB; m_t = 0; end
                            else if (m_t + 1 >= TO) begin m_to = 1; m_ph = PH_PLL; m_t = 0; end
                            else m_t++;
                        PH_STB:
                            if (!lk) begin m_ph = PH_WAIT; m_t = 0; end
                            else if (m_t + 1 >= STB) begin m_ph = PH_UP; m_t = 0; end
                            else m_t++;
                        default:
                            if (!lk) begin
                                if (m_loss < 255) m_loss++;
                                m_ph = PH_WAIT; m_t = 0;
                            end else if (m_t < 1000) m_t++;
                    endcase
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("pll_rst", int'(bus.pll_rst), (m_ph == PH_PLL) ? 1 : 0);
            check("dom_rst", int'(bus.dom_rst), exp_dom());
            check("all_ready", int'(bus.all_ready), exp_ready());
            check("loss_count", int'(bus.loss_count), m_loss);
            check("timeout_err", int'(bus.timeout_err), m_to);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_dom0(input int lim);
        int k = 0;
        while (bus.dom_rst[0] && k < lim) begin @(negedge clk); k++; end
        check("wait_dom0", int'(bus.dom_rst[0]), 0);
    endtask

    task automatic wait_ready(input int lim);
        int k = 0;
        while (!bus.all_ready && k < lim) begin @(negedge clk); k++; end
        check("wait_ready", int'(bus.all_ready), 1);
    endtask

    initial begin
        int p, lat;
        int t0, t1, t2, tr;
        bus.ext_rst   = 1'b0;
        bus.lock_in   = '0;
        bus.lock_mask = '1;
        rst_n = 1'b0;
        cycles(5);
        check("rst_pll", int'(bus.pll_rst), 1);
        check("rst_dom", int'(bus.dom_rst), 7);
        check("rst_ready", int'(bus.all_ready), 0);
        check("rst_loss", int'(bus.loss_count), 0);
        check("rst_to", int'(bus.timeout_err), 0);
        rst_n = 1'b1;

        // Power-up: pll pulse width, then staged release
        p = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.pll_rst) p++;
            @(negedge clk);
        end
        check("pll_width", p, 3);
        bus.lock_in = '1;
        t0 = -1; t1 = -1; t2 = -1; tr = -1;
        for (int i = 0; i < 40; i++) begin
            if (t0 < 0 && !bus.dom_rst[0]) t0 = i;
            if (t1 < 0 && !bus.dom_rst[1]) t1 = i;
            if (t2 < 0 && !bus.dom_rst[2]) t2 = i;
            if (tr < 0 && bus.all_ready) tr = i;
            @(negedge clk);
        end
        check("lock_to_dom0", t0, 11);
        check("gap01", t1 - t0, 4);
        check("gap12", t2 - t1, 4);
        check("ready_after_dom2", tr - t2, 1);

        // Short lock loss in RUN
        bus.lock_in = 2'b01;
        @(negedge clk);
        bus.lock_in = 2'b11;
        lat = 1;
        while (bus.dom_rst != 3'b111 && lat < 10) begin @(negedge clk); lat++; end
        check("loss_latency", lat, 3);
        check("loss_one", int'(bus.loss_count), 1);
        check("model_loss_one", m_loss, 1);
        wait_ready(60);

        // Lock never returns: periodic PLL retry
        bus.lock_in = '0;
        cycles(80);
        check("timeout_set", int'(bus.timeout_err), 1);
        p = 0;
        for (int i = 0; i < 3 * 67; i++) begin
            if (bus.pll_rst) p++;
            @(negedge clk);
        end
        check("retry_pll_cycles", p, 9);

        // Masked PLL ignored
        bus.lock_mask = 2'b01;
        bus.lock_in   = 2'b01;
        wait_ready(200);
        for (int i = 0; i < 20; i++) begin
            bus.lock_in[1] = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("mask_ready", int'(bus.all_ready), 1);
        check("mask_loss", int'(bus.loss_count), 2);
        bus.lock_mask = 2'b11;
        bus.lock_in   = 2'b11;

        // ext_rst during RELEASE, alone then with a lock drop
        for (int r = 0; r < 2; r++) begin
            bus.ext_rst = 1'b1;
            @(negedge clk);
            bus.ext_rst = 1'b0;
            wait_dom0(60);
            bus.ext_rst = 1'b1;
            if (r == 1) bus.lock_in = 2'b00;
            cycles(3);
            bus.ext_rst = 1'b0;
            bus.lock_in = 2'b11;
            cycles(2);
            check("ext_pll", int'(bus.pll_rst), 1);
            check("ext_dom", int'(bus.dom_rst), 7);
            check("ext_loss", int'(bus.loss_count), 2);
        end

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            bus.lock_in = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            bus.ext_rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) bus.lock_mask = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        bus.lock_mask = 2'b11;
        bus.lock_in   = 2'b11;
        bus.ext_rst   = 1'b0;

        // Drive loss count into saturation
        for (int i = 0; i < 300; i++) begin
            wait_dom0(100);
            bus.lock_in = 2'($urandom_range(0, 2));
            cycles($urandom_range(1, 3));
            bus.lock_in = 2'b11;
            cycles(3);
        end
        check("loss_sat", int'(bus.loss_count), 255);
        check("model_loss_sat", m_loss, 255);

        // Async reset mid-RELEASE
        wait_dom0(100);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_pll", int'(bus.pll_rst), 1);
        check("arst_dom", int'(bus.dom_rst), 7);
        check("arst_ready", int'(bus.all_ready), 0);
        check("arst_loss", int'(bus.loss_count), 0);
        check("arst_to", int'(bus.timeout_err), 0);
        check("model_arst_loss", m_loss, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
